// File: rtl/shift_left_logical_seq.sv
// Multi-cycle left shifter: resolves one shamt bit per clock, ready/valid on both sides.
// Optional rotate-left mode is enabled by defining SHIFT_LEFT_ROTATE_EN.
module shift_left_logical_seq #(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    input  logic [S-1:0] shamt,
`ifdef SHIFT_LEFT_ROTATE_EN
    input  logic         rotate,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [1:0]   state_dbg_o
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and out is held
    // stable from the rise of out_valid until the transfer.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned KL     = S - 1;
    localparam logic [S-1:0] K_LAST = KL[S-1:0];

    state_t         state_q;
    logic [N-1:0]   data_q;
    logic [N-1:0]   data_d;
    logic [S-1:0]   amt_q;
    logic [S-1:0]   k_q;
    logic [N-1:0]   out_q;
`ifdef SHIFT_LEFT_ROTATE_EN
    logic           rot_q;
`endif

    // Stage k moves the word by 2^k when amt_q[k] is set; only the current stage applies.
    always_comb begin
        data_d = data_q;
        for (int j = 0; j < S; j++) begin
            if (k_q == j[S-1:0] && amt_q[j]) begin
`ifdef SHIFT_LEFT_ROTATE_EN
                if (rot_q)
                    data_d = (data_q << (1 << j)) | (data_q >> (N - (1 << j)));
                else
                    data_d = data_q << (1 << j);
`else
                data_d = data_q << (1 << j);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            k_q     <= '0;
            out_q   <= '0;
`ifdef SHIFT_LEFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in;
                        amt_q   <= shamt;
                        k_q     <= '0;
`ifdef SHIFT_LEFT_ROTATE_EN
                        rot_q   <= rotate;
`endif
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    k_q    <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        out_q   <= data_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out         = out_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Bench for shift_left_logical_seq: directed corner cases plus randomized traffic,
// checked through an expected queue against a shift/rotate reference model.
module tb_shift_left_logical_seq;
  localparam int N = 32;
  localparam int S = 5;
`ifdef SHIFT_LEFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] shamt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   state_dbg;
`ifdef SHIFT_LEFT_ROTATE_EN
  logic         rotate;
`endif

  shift_left_logical_seq #(.N(N), .S(S)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in(in_data),
    .shamt(shamt),
`ifdef SHIFT_LEFT_ROTATE_EN
    .rotate(rotate),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out_data),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  int           acc_q[$];
  int           total = 0;
  int           bad = 0;
  bit           rdy_rand = 1'b0;
  bit           rdy_fixed = 1'b1;
  bit           mon_prev_valid = 1'b0;
  bit           mon_prev_hs = 1'b0;
  int           mon_acc;

  // Logical shift is multiplication by 2^s modulo 2^N; rotate-left reads the
  // upper half of the doubled word after shifting.
  function automatic logic [N-1:0] model(input logic [N-1:0] v, input int s, input bit rot);
    logic [2*N-1:0] w;
    logic [63:0]    p;
    if (rot) begin
      w = {v, v} << s;
      return w[2*N-1:N];
    end
    p = 64'(v) * (64'd1 << s);
    return p[N-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] v, input logic [S-1:0] s, input bit rot);
    int waited = 0;
    bit done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    shamt    = s;
`ifdef SHIFT_LEFT_ROTATE_EN
    rotate   = rot;
`endif
    while (!done) begin
      #4;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        exp_q.push_back(model(v, int'(s), ROT_EN && rot));
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 100) begin
          chk("accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 1) != 0) : rdy_fixed;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        mon_prev_valid = 1'b0;
        mon_prev_hs    = 1'b0;
      end else begin
        if (mon_prev_hs) begin
          chk("in_ready_after_hs", 64'(in_ready), 64'd1);
          chk("valid_drop_after_hs", 64'(out_valid), 64'd0);
        end else if (mon_prev_valid) begin
          chk("valid_held", 64'(out_valid), 64'd1);
        end
        if (out_valid) begin
          chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
          if (!mon_prev_valid) begin
            if (acc_q.size() == 0) begin
              chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
              mon_acc = acc_q.pop_front();
              chk("latency", 64'(cyc - mon_acc), 64'(S));
            end
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            chk("out_value", 64'(out_data), 64'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        mon_prev_hs    = out_valid && out_ready;
        mon_prev_valid = out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    shamt    = '0;
`ifdef SHIFT_LEFT_ROTATE_EN
    rotate   = 1'b0;
`endif
    #1;
    chk("reset_out", 64'(out_data), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed corners with a consumer that is always ready
    rdy_fixed = 1'b1;
    send(32'h0000_0001, 5'd31, 1'b0);
    drain();
    send(32'hDEAD_BEEF, 5'd0, 1'b0);
    drain();
    send(32'h8000_0001, 5'd4, 1'b0);
    drain();
    send(32'h8000_0001, 5'd4, 1'b1);
    drain();
    send(32'hFFFF_FFFF, 5'd31, 1'b1);
    drain();

    // result held while consumer stalls; extra in_valid is ignored
    rdy_fixed = 1'b0;
    send(32'hF0F0_F0F0, 5'd8, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      shamt    = 5'd1;
      #4;
      chk("hold_out", 64'(out_data), 64'h0000_0000_F0F0_F000);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    rdy_fixed = 1'b1;
    @(negedge clk);
    rdy_fixed = 1'b0;
    #4;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    rdy_fixed = 1'b1;
    drain();

    // reset two cycles into SHIFT discards the operation
    send(32'hFFFF_FFFF, 5'd4, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_out", 64'(out_data), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (S + 3) @(negedge clk);
    #4;
    chk("post_rst_out", 64'(out_data), 64'd0);
    chk("post_rst_idle", 64'(state_dbg), 64'd0);

    // randomized traffic with a randomly stalling consumer
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send($urandom, 5'($urandom_range(0, N - 1)), $urandom_range(0, 1) != 0);
    end
    drain();
    rdy_rand = 1'b0;
    chk("latency_queue_empty", 64'(acc_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
